// File: rtl/hilo_mdu_pkg.sv
// Shared HI/LO unit definitions: operation codes, FSM states and small arithmetic helpers.
package hilo_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NONE  = 3'd7
  } hilo_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mdu_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_mdu.sv
// E-stage HI/LO multiply/divide unit: MTHI/MTLO write immediately, mul/div results
// are computed at accept and committed after a fixed latency while busy is held high.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  HILOop,
  input  logic        HILOwe,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  typedef logic [CW-1:0] cnt_t;

  mdu_state_e  state_q;
  cnt_t        cnt_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_we_q;

  hilo_op_e    op;
  logic [63:0] prod_s, prod_u;
  logic        is_signed_div, is_muldiv;
  logic [31:0] dvd, dvs, q_mag, r_mag;
  logic [31:0] res_hi_d, res_lo_d;
  logic        res_we_d;
  cnt_t        lat_d;

  assign op = hilo_op_e'(HILOop);

  // One divider serves DIV and DIVU: signed ops divide magnitudes and fix signs after.
  // A zero divisor is replaced by 1 only to keep the datapath defined; its result is dropped.
  always_comb begin
    prod_s        = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u        = {32'd0, A} * {32'd0, B};
    is_signed_div = (op == OP_DIV);
    dvd           = is_signed_div ? abs32(A) : A;
    dvs           = is_signed_div ? abs32(B) : B;
    if (dvs == '0) begin
      dvs = 32'd1;
    end
    q_mag = dvd / dvs;
    r_mag = dvd % dvs;

    res_hi_d  = '0;
    res_lo_d  = '0;
    res_we_d  = 1'b0;
    is_muldiv = 1'b0;
    lat_d     = cnt_t'(DIV_CYCLES);
    case (op)
      OP_MULT: begin
        {res_hi_d, res_lo_d} = prod_s;
        res_we_d  = 1'b1;
        is_muldiv = 1'b1;
        lat_d     = cnt_t'(MULT_CYCLES);
      end
      OP_MULTU: begin
        {res_hi_d, res_lo_d} = prod_u;
        res_we_d  = 1'b1;
        is_muldiv = 1'b1;
        lat_d     = cnt_t'(MULT_CYCLES);
      end
      OP_DIV: begin
        res_lo_d  = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
        res_hi_d  = A[31] ? (~r_mag + 32'd1) : r_mag;
        res_we_d  = (B != '0);
        is_muldiv = 1'b1;
      end
      OP_DIVU: begin
        res_lo_d  = q_mag;
        res_hi_d  = r_mag;
        res_we_d  = (B != '0);
        is_muldiv = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy      <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (HILOwe) begin
            if (op == OP_MTHI) begin
              HI <= A;
            end else if (op == OP_MTLO) begin
              LO <= A;
            end else if (is_muldiv) begin
              pend_hi_q <= res_hi_d;
              pend_lo_q <= res_lo_d;
              pend_we_q <= res_we_d;
              cnt_q     <= lat_d;
              busy      <= 1'b1;
              state_q   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (cnt_q == cnt_t'(1)) begin
            if (pend_we_q) begin
              HI <= pend_hi_q;
              LO <= pend_lo_q;
            end
            cnt_q   <= '0;
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu: cycle-level reference model plus hand-computed result checks.
module tb_hilo_mdu;
  import hilo_mdu_pkg::*;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic [2:0]  HILOop = OP_NONE;
  logic        HILOwe = 1'b0;
  logic        busy;
  logic [31:0] HI, LO;

  hilo_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .HILOop(HILOop), .HILOwe(HILOwe),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Reference model: remaining-latency count and a pending result, arithmetic via longint.
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  logic        m_pwe = 1'b0;
  int          m_rem = 0;
  longint      sp;
  longint unsigned up;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_pwe = 1'b0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0 && m_pwe) begin
        m_hi = m_phi; m_lo = m_plo;
      end
    end else if (HILOwe) begin
      case (HILOop)
        OP_MTHI: m_hi = A;
        OP_MTLO: m_lo = A;
        OP_MULT: begin
          sp = longint'($signed(A)) * longint'($signed(B));
          m_phi = sp[63:32]; m_plo = sp[31:0]; m_pwe = 1'b1; m_rem = MULT_N;
        end
        OP_MULTU: begin
          up = longint'({32'd0, A}) * longint'({32'd0, B});
          m_phi = up[63:32]; m_plo = up[31:0]; m_pwe = 1'b1; m_rem = MULT_N;
        end
        OP_DIV: begin
          m_pwe = (B != 0); m_rem = DIV_N;
          if (B != 0) begin
            sp = longint'($signed(A)) / longint'($signed(B)); m_plo = sp[31:0];
            sp = longint'($signed(A)) % longint'($signed(B)); m_phi = sp[31:0];
          end
        end
        OP_DIVU: begin
          m_pwe = (B != 0); m_rem = DIV_N;
          if (B != 0) begin
            m_plo = A / B; m_phi = A % B;
          end
        end
        default: ;
      endcase
    end
  end

  // Issuing while busy is a pipeline contract violation, except where deliberately provoked.
  logic allow_we_busy = 1'b0;
  int   we_busy_seen = 0;
  always @(posedge clk) begin
    if (!reset && busy && HILOwe) begin
      we_busy_seen++;
      assert (allow_we_busy) else $error("HILOwe asserted while busy");
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("busy", {31'd0, busy}, {31'd0, (m_rem != 0)});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    HILOop = op; A = a; B = b; HILOwe = 1'b1;
    step();
    HILOwe = 1'b0; HILOop = OP_NONE;
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy && n < 60) begin
      n++;
      step();
    end
    if (busy) chk(name, {31'd0, busy}, 32'd0);
  endtask

  int n;

  initial begin
    step(); step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_HI", HI, 32'd0);
    chk("reset_LO", LO, 32'd0);
    reset = 1'b0;

    issue(OP_MTHI, 32'h12345678, 32'd0);
    chk("mthi_HI", HI, 32'h12345678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(OP_MTLO, 32'h9ABCDEF0, 32'd0);
    chk("mtlo_LO", LO, 32'h9ABCDEF0);
    chk("mtlo_HI", HI, 32'h12345678);
    issue(OP_NONE, 32'hDEADBEEF, 32'd1);
    chk("none_HI", HI, 32'h12345678);
    chk("none_LO", LO, 32'h9ABCDEF0);

    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult_hold_HI", HI, 32'h12345678);
    wait_idle("mult_timeout", n);
    chk("mult_latency", n, MULT_N);
    chk("mult_HI", HI, 32'hFFFFFFFF);
    chk("mult_LO", LO, 32'hFFFFFFFA);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle("multu_timeout", n);
    chk("multu_latency", n, MULT_N);
    chk("multu_HI", HI, 32'hFFFFFFFE);
    chk("multu_LO", LO, 32'h00000001);

    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_timeout", n);
    chk("div_latency", n, DIV_N);
    chk("div_LO", LO, 32'hFFFFFFFD);
    chk("div_HI", HI, 32'hFFFFFFFF);

    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("divovf_timeout", n);
    chk("divovf_LO", LO, 32'h80000000);
    chk("divovf_HI", HI, 32'h00000000);

    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle("divu_timeout", n);
    chk("divu_LO", LO, 32'd14);
    chk("divu_HI", HI, 32'd2);

    issue(OP_MTHI, 32'h11, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_idle("div0_timeout", n);
    chk("div0_latency", n, DIV_N);
    chk("div0_HI", HI, 32'h11);
    chk("div0_LO", LO, 32'h22);

    issue(OP_MULTU, 32'd6, 32'd7);
    allow_we_busy = 1'b1;
    HILOop = OP_MTHI; A = 32'hDEADBEEF; HILOwe = 1'b1;
    step();
    HILOwe = 1'b0; HILOop = OP_NONE;
    allow_we_busy = 1'b0;
    wait_idle("ign_timeout", n);
    chk("ign_HI", HI, 32'd0);
    chk("ign_LO", LO, 32'd42);
    chk("ign_seen", we_busy_seen, 32'd1);

    issue(OP_DIV, 32'd100, 32'd7);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_HI", HI, 32'd0);
    chk("rst_mid_LO", LO, 32'd0);
    for (int i = 0; i < 12; i++) step();
    chk("rst_late_HI", HI, 32'd0);
    chk("rst_late_LO", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
